// File: rtl/bus_err_unit_pkg.sv
// Shared types and helpers for the ID-aware bus error unit.
package bus_err_unit_pkg;

  // What the error FIFO does with an incoming record this cycle.
  typedef enum logic [1:0] {
    PUSH_NONE,
    PUSH_STORE,
    PUSH_DROP,
    PUSH_OVERWRITE
  } push_act_e;

  // Next ring index; depth need not be a power of two.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned depth);
    return (idx + 32'd1 == depth) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/bus_err_unit_id_if.sv
// Bus-side bundle of the ID-aware error unit: request/response snoop plus error-record readout.
interface bus_err_unit_id_if #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3,
  parameter int unsigned IdWidth       = 2,
  parameter int unsigned NumReqPorts   = 1,
  parameter int unsigned NumChannels   = 1,
  parameter int unsigned DropCntWidth  = 8
) ();
  logic [NumReqPorts-1:0][NumChannels-1:0]   req_hs_valid;
  logic [NumReqPorts-1:0][IdWidth-1:0]       req_id;
  logic [NumReqPorts-1:0][AddrWidth-1:0]     req_addr;
  logic [NumReqPorts-1:0][MetaDataWidth-1:0] req_meta;
  logic [NumChannels-1:0]                    rsp_hs_valid;
  logic [NumChannels-1:0]                    rsp_burst_last;
  logic [IdWidth-1:0]                        rsp_id;
  logic [ErrBits-1:0]                        rsp_err;
  logic                                      err_irq;
  logic                                      err_fifo_pop;
  logic [ErrBits-1:0]                        err_code;
  logic [AddrWidth-1:0]                      err_addr;
  logic [MetaDataWidth-1:0]                  err_meta;
  logic [IdWidth-1:0]                        err_id;
  logic [NumChannels-1:0]                    err_chan;
  logic                                      err_addr_valid;
  logic                                      err_fifo_overflow;
  logic [DropCntWidth-1:0]                   drop_cnt;
  logic                                      drop_clr;

  modport master (
    output req_hs_valid, req_id, req_addr, req_meta,
    output rsp_hs_valid, rsp_burst_last, rsp_id, rsp_err,
    output err_fifo_pop, drop_clr,
    input  err_irq, err_code, err_addr, err_meta, err_id, err_chan,
    input  err_addr_valid, err_fifo_overflow, drop_cnt
  );

  modport slave (
    input  req_hs_valid, req_id, req_addr, req_meta,
    input  rsp_hs_valid, rsp_burst_last, rsp_id, rsp_err,
    input  err_fifo_pop, drop_clr,
    output err_irq, err_code, err_addr, err_meta, err_id, err_chan,
    output err_addr_valid, err_fifo_overflow, drop_cnt
  );
endinterface

// File: rtl/bus_err_unit_id_table.sv
// Per-channel outstanding-request table indexed by ID, with collision tracking and a read port.
// With BUS_ERR_UNIT_TIMEOUT_EN defined, also hosts the channel watchdog.
module bus_err_unit_id_table
  import bus_err_unit_pkg::*;
#(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned IdWidth       = 2
`ifdef BUS_ERR_UNIT_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_valid,
  input  logic [IdWidth-1:0]       alloc_id,
  input  logic [AddrWidth-1:0]     alloc_addr,
  input  logic [MetaDataWidth-1:0] alloc_meta,
  input  logic                     rsp_valid,
  input  logic                     rsp_last,
  input  logic [IdWidth-1:0]       rsp_id,
  output logic                     rd_ok,
  output logic [AddrWidth-1:0]     rd_addr,
  output logic [MetaDataWidth-1:0] rd_meta
`ifdef BUS_ERR_UNIT_TIMEOUT_EN
  , output logic                     tmo_req
  , output logic [IdWidth-1:0]       tmo_id
  , output logic                     tmo_ok
  , output logic [AddrWidth-1:0]     tmo_addr
  , output logic [MetaDataWidth-1:0] tmo_meta
  , input  logic                     tmo_ack
`endif
);
  localparam int unsigned NumIds = 2 ** IdWidth;

  logic [NumIds-1:0]        valid_q;
  logic [NumIds-1:0]        collide_q;
  logic [AddrWidth-1:0]     addr_q [NumIds];
  logic [MetaDataWidth-1:0] meta_q [NumIds];
  logic [NumIds-1:0]        rel;

  assign rd_ok   = valid_q[rsp_id] & ~collide_q[rsp_id];
  assign rd_addr = rd_ok ? addr_q[rsp_id] : '0;
  assign rd_meta = rd_ok ? meta_q[rsp_id] : '0;

  always_comb begin
    rel = '0;
    if (rsp_valid && rsp_last) rel[rsp_id] = 1'b1;
`ifdef BUS_ERR_UNIT_TIMEOUT_EN
    if (tmo_ack) rel[tmo_id] = 1'b1;
`endif
  end

  // Alloc beats release on the same entry and restarts it clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      collide_q <= '0;
      for (int unsigned i = 0; i < NumIds; i++) begin
        addr_q[i] <= '0;
        meta_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        if (alloc_valid && alloc_id == IdWidth'(i)) begin
          valid_q[i]   <= 1'b1;
          collide_q[i] <= valid_q[i] & ~rel[i];
          addr_q[i]    <= alloc_addr;
          meta_q[i]    <= alloc_meta;
        end else if (rel[i]) begin
          valid_q[i]   <= 1'b0;
          collide_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef BUS_ERR_UNIT_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q;
  logic            any_valid;

  assign any_valid = |valid_q;

  always_comb begin
    tmo_id = '0;
    for (int unsigned i = NumIds; i > 0; i--) begin
      if (valid_q[i-1]) tmo_id = IdWidth'(i - 1);
    end
  end

  assign tmo_ok   = ~collide_q[tmo_id];
  assign tmo_addr = tmo_ok ? addr_q[tmo_id] : '0;
  assign tmo_meta = tmo_ok ? meta_q[tmo_id] : '0;
  assign tmo_req  = any_valid && !rsp_valid && (cnt_q == CntW'(TimeoutCycles - 1));

  // Counter parks at its limit until the top grants the timeout push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rsp_valid || !any_valid || tmo_ack) begin
      cnt_q <= '0;
    end else if (cnt_q != CntW'(TimeoutCycles - 1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n && rsp_valid) begin
      assert (valid_q[rsp_id])
        else $warning("response on ID %0d with no outstanding request", rsp_id);
    end
  end

endmodule

// File: rtl/bus_err_unit_id.sv
// ID-aware bus error unit: per-channel ID tables feed an error-record FIFO.
// Optional watchdog: define BUS_ERR_UNIT_TIMEOUT_EN.
module bus_err_unit_id
  import bus_err_unit_pkg::*;
#(
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned MetaDataWidth   = 1,
  parameter int unsigned ErrBits         = 3,
  parameter int unsigned IdWidth         = 2,
  parameter int unsigned NumStoredErrors = 4,
  parameter int unsigned NumReqPorts     = 1,
  parameter int unsigned NumChannels     = 1,
  parameter bit          DropOldest      = 1'b0,
  parameter int unsigned DropCntWidth    = 8,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  bus_err_unit_id_if.slave  bus
);
  typedef struct packed {
    logic [ErrBits-1:0]       err;
    logic [NumChannels-1:0]   chan;
    logic [IdWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [MetaDataWidth-1:0] meta;
    logic                     addr_valid;
  } err_rec_t;

  localparam int unsigned PtrW = $clog2(NumStoredErrors);
  localparam int unsigned CntW = $clog2(NumStoredErrors + 1);

  logic [NumChannels-1:0]                    alloc_valid;
  logic [NumChannels-1:0][IdWidth-1:0]       alloc_id;
  logic [NumChannels-1:0][AddrWidth-1:0]     alloc_addr;
  logic [NumChannels-1:0][MetaDataWidth-1:0] alloc_meta;
  logic [NumChannels-1:0][NumReqPorts-1:0]   req_col;
  logic [NumChannels-1:0]                    rd_ok;
  logic [NumChannels-1:0][AddrWidth-1:0]     rd_addr;
  logic [NumChannels-1:0][MetaDataWidth-1:0] rd_meta;

  always_comb begin
    alloc_valid = '0;
    alloc_id    = '0;
    alloc_addr  = '0;
    alloc_meta  = '0;
    req_col     = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      for (int unsigned p = 0; p < NumReqPorts; p++) begin
        req_col[c][p] = bus.req_hs_valid[p][c];
        if (bus.req_hs_valid[p][c] && !alloc_valid[c]) begin
          alloc_valid[c] = 1'b1;
          alloc_id[c]    = bus.req_id[p];
          alloc_addr[c]  = bus.req_addr[p];
          alloc_meta[c]  = bus.req_meta[p];
        end
      end
    end
  end

`ifdef BUS_ERR_UNIT_TIMEOUT_EN
  localparam logic [ErrBits-1:0] ErrTimeout = '1;
  logic [NumChannels-1:0]                    tmo_req;
  logic [NumChannels-1:0]                    tmo_ack;
  logic [NumChannels-1:0][IdWidth-1:0]       tmo_id;
  logic [NumChannels-1:0]                    tmo_ok;
  logic [NumChannels-1:0][AddrWidth-1:0]     tmo_addr;
  logic [NumChannels-1:0][MetaDataWidth-1:0] tmo_meta;
`endif

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    bus_err_unit_id_table #(
      .AddrWidth     (AddrWidth),
      .MetaDataWidth (MetaDataWidth),
      .IdWidth       (IdWidth)
`ifdef BUS_ERR_UNIT_TIMEOUT_EN
      , .TimeoutCycles (TimeoutCycles)
`endif
    ) u_table (
      .clk         (clk_i),
      .rst_n       (rst_ni),
      .alloc_valid (alloc_valid[c]),
      .alloc_id    (alloc_id[c]),
      .alloc_addr  (alloc_addr[c]),
      .alloc_meta  (alloc_meta[c]),
      .rsp_valid   (bus.rsp_hs_valid[c]),
      .rsp_last    (bus.rsp_burst_last[c]),
      .rsp_id      (bus.rsp_id),
      .rd_ok       (rd_ok[c]),
      .rd_addr     (rd_addr[c]),
      .rd_meta     (rd_meta[c])
`ifdef BUS_ERR_UNIT_TIMEOUT_EN
      , .tmo_req   (tmo_req[c])
      , .tmo_id    (tmo_id[c])
      , .tmo_ok    (tmo_ok[c])
      , .tmo_addr  (tmo_addr[c])
      , .tmo_meta  (tmo_meta[c])
      , .tmo_ack   (tmo_ack[c])
`endif
    );
  end

  err_rec_t rsp_rec;
  err_rec_t push_rec;
  logic     rsp_push;
  logic     push;

  assign rsp_push = (|bus.rsp_hs_valid) && (bus.rsp_err != '0);

  always_comb begin
    rsp_rec      = '0;
    rsp_rec.err  = bus.rsp_err;
    rsp_rec.chan = bus.rsp_hs_valid;
    rsp_rec.id   = bus.rsp_id;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (bus.rsp_hs_valid[c]) begin
        rsp_rec.addr_valid = rd_ok[c];
        rsp_rec.addr       = rd_addr[c];
        rsp_rec.meta       = rd_meta[c];
      end
    end
  end

`ifdef BUS_ERR_UNIT_TIMEOUT_EN
  err_rec_t tmo_rec;

  // Response errors own the single FIFO write port; timeouts wait a cycle.
  always_comb begin
    tmo_ack = '0;
    tmo_rec = '0;
    if (!rsp_push) begin
      for (int unsigned c = NumChannels; c > 0; c--) begin
        if (tmo_req[c-1]) begin
          tmo_ack            = '0;
          tmo_ack[c-1]       = 1'b1;
          tmo_rec            = '0;
          tmo_rec.err        = ErrTimeout;
          tmo_rec.chan[c-1]  = 1'b1;
          tmo_rec.id         = tmo_id[c-1];
          tmo_rec.addr       = tmo_addr[c-1];
          tmo_rec.meta       = tmo_meta[c-1];
          tmo_rec.addr_valid = tmo_ok[c-1];
        end
      end
    end
  end

  assign push     = rsp_push | (|tmo_ack);
  assign push_rec = rsp_push ? rsp_rec : tmo_rec;
`else
  assign push     = rsp_push;
  assign push_rec = rsp_rec;
`endif

  err_rec_t                mem_q [NumStoredErrors];
  err_rec_t                head;
  logic [PtrW-1:0]         rd_ptr_q, wr_ptr_q, rd_nxt, wr_nxt;
  logic [CntW-1:0]         count_q;
  logic [DropCntWidth-1:0] drop_cnt_q;
  logic                    overflow_q;
  logic                    empty, full, pop, drop;
  push_act_e               act;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(NumStoredErrors));
  assign pop    = bus.err_fifo_pop & ~empty;
  assign rd_nxt = PtrW'(ring_next(32'(rd_ptr_q), NumStoredErrors));
  assign wr_nxt = PtrW'(ring_next(32'(wr_ptr_q), NumStoredErrors));
  assign drop   = (act == PUSH_DROP) || (act == PUSH_OVERWRITE);

  always_comb begin
    act = PUSH_NONE;
    if (push) begin
      if (!full || pop)    act = PUSH_STORE;
      else if (DropOldest) act = PUSH_OVERWRITE;
      else                 act = PUSH_DROP;
    end
  end

  // Overwrite on full: write lands on the head slot and both pointers advance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < NumStoredErrors; i++) mem_q[i] <= '0;
    end else begin
      if (act == PUSH_STORE || act == PUSH_OVERWRITE) begin
        mem_q[wr_ptr_q] <= push_rec;
        wr_ptr_q        <= wr_nxt;
      end
      if (pop || act == PUSH_OVERWRITE) rd_ptr_q <= rd_nxt;
      if (act == PUSH_STORE && !pop)      count_q <= count_q + 1'b1;
      else if (act == PUSH_NONE && pop)   count_q <= count_q - 1'b1;
      if (bus.drop_clr) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign head                  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.err_irq           = ~empty;
  assign bus.err_code          = head.err;
  assign bus.err_addr          = head.addr;
  assign bus.err_meta          = head.meta;
  assign bus.err_id            = head.id;
  assign bus.err_chan          = head.chan;
  assign bus.err_addr_valid    = head.addr_valid;
  assign bus.err_fifo_overflow = overflow_q;
  assign bus.drop_cnt          = drop_cnt_q;

  always_ff @(posedge clk_i) begin
    assert (NumStoredErrors >= 2 && TimeoutCycles > 0) else $error("bad parameters");
    if (rst_ni) begin
      assert ($onehot0(bus.rsp_hs_valid)) else $error("rsp_hs_valid not one-hot");
      for (int unsigned p = 0; p < NumReqPorts; p++) begin
        assert ($onehot0(bus.req_hs_valid[p])) else $error("req port %0d not one-hot", p);
      end
      for (int unsigned c = 0; c < NumChannels; c++) begin
        assert ($onehot0(req_col[c])) else $error("channel %0d requested by several ports", c);
      end
    end
  end

endmodule

// File: tb/tb_bus_err_unit_id.sv
// Directed bench for bus_err_unit_id: drop-newest (dut0) and drop-oldest (dut1) see identical stimulus.
module tb_bus_err_unit_id;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_v;
  logic [1:0]  req_id;
  logic [47:0] req_addr;
  logic        req_meta;
  logic        rsp_v, rsp_last;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_err;
  logic        pop, clr;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n;

  bus_err_unit_id_if if0 ();
  bus_err_unit_id_if if1 ();

  assign if0.req_hs_valid = req_v;    assign if1.req_hs_valid = req_v;
  assign if0.req_id       = req_id;   assign if1.req_id       = req_id;
  assign if0.req_addr     = req_addr; assign if1.req_addr     = req_addr;
  assign if0.req_meta     = req_meta; assign if1.req_meta     = req_meta;
  assign if0.rsp_hs_valid = rsp_v;    assign if1.rsp_hs_valid = rsp_v;
  assign if0.rsp_burst_last = rsp_last; assign if1.rsp_burst_last = rsp_last;
  assign if0.rsp_id       = rsp_id;   assign if1.rsp_id       = rsp_id;
  assign if0.rsp_err      = rsp_err;  assign if1.rsp_err      = rsp_err;
  assign if0.err_fifo_pop = pop;      assign if1.err_fifo_pop = pop;
  assign if0.drop_clr     = clr;      assign if1.drop_clr     = clr;

  bus_err_unit_id #(.DropOldest(1'b0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
  bus_err_unit_id #(.DropOldest(1'b1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_v = 1'b0; req_id = '0; req_addr = '0; req_meta = 1'b0;
    rsp_v = 1'b0; rsp_last = 1'b0; rsp_id = '0; rsp_err = '0;
    pop = 1'b0; clr = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] id, input logic [47:0] a, input logic m);
    req_v = 1'b1; req_id = id; req_addr = a; req_meta = m;
    tick();
    idle();
  endtask

  task automatic do_rsp(input logic [1:0] id, input logic [2:0] e, input logic last);
    rsp_v = 1'b1; rsp_id = id; rsp_err = e; rsp_last = last;
    tick();
    idle();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst irq0",  64'(if0.err_irq), 64'd0);
    check("rst irq1",  64'(if1.err_irq), 64'd0);
    check("rst code",  64'(if0.err_code), 64'd0);
    check("rst addr",  64'(if0.err_addr), 64'd0);
    check("rst drop",  64'(if0.drop_cnt), 64'd0);
    check("rst ovf",   64'(if0.err_fifo_overflow), 64'd0);

    // out-of-order response resolves to its own ID
    do_req(2'd2, 48'h1000, 1'b0);
    do_req(2'd1, 48'h2000, 1'b1);
    rsp_v = 1'b1; rsp_id = 2'd1; rsp_err = 3'd3; rsp_last = 1'b1;
    check("t1 irq same cycle", 64'(if0.err_irq), 64'd0);
    tick();
    idle();
    check("t1 irq",   64'(if0.err_irq), 64'd1);
    check("t1 code",  64'(if0.err_code), 64'd3);
    check("t1 id",    64'(if0.err_id), 64'd1);
    check("t1 addr",  64'(if0.err_addr), 64'h2000);
    check("t1 meta",  64'(if0.err_meta), 64'd1);
    check("t1 av",    64'(if0.err_addr_valid), 64'd1);
    check("t1 chan",  64'(if0.err_chan), 64'd1);
    do_pop();
    check("t1 popped", 64'(if0.err_irq), 64'd0);
    do_rsp(2'd2, 3'd0, 1'b1);
    check("t1 ok beat no push", 64'(if0.err_irq), 64'd0);

    // ID collision
    do_req(2'd0, 48'h10, 1'b0);
    do_req(2'd0, 48'h20, 1'b1);
    do_rsp(2'd0, 3'd5, 1'b1);
    check("t2 code", 64'(if0.err_code), 64'd5);
    check("t2 av",   64'(if0.err_addr_valid), 64'd0);
    check("t2 addr", 64'(if0.err_addr), 64'd0);
    check("t2 meta", 64'(if0.err_meta), 64'd0);
    check("t2 id",   64'(if0.err_id), 64'd0);
    do_pop();

    // release and re-alloc of id3 in one cycle
    do_req(2'd3, 48'hAAAA, 1'b0);
    rsp_v = 1'b1; rsp_id = 2'd3; rsp_err = 3'd0; rsp_last = 1'b1;
    req_v = 1'b1; req_id = 2'd3; req_addr = 48'hBBBB; req_meta = 1'b1;
    tick();
    idle();
    check("t5 no push", 64'(if0.err_irq), 64'd0);
    do_rsp(2'd3, 3'd2, 1'b1);
    check("t5 code", 64'(if0.err_code), 64'd2);
    check("t5 addr", 64'(if0.err_addr), 64'hBBBB);
    check("t5 av",   64'(if0.err_addr_valid), 64'd1);
    check("t5 meta", 64'(if0.err_meta), 64'd1);
    do_pop();

    // overflow: codes 1..6 on ids 0,1,2,3,0,1 with non-last beats
    for (int i = 0; i < 4; i++) do_req(2'(i), 48'(32'h100 * (i + 1)), 1'b0);
    for (int k = 1; k <= 4; k++) do_rsp(2'(k - 1), 3'(k), 1'b0);
    check("t3 full drop0", 64'(if0.drop_cnt), 64'd0);
    check("t3 full ovf0",  64'(if0.err_fifo_overflow), 64'd0);
    do_rsp(2'd0, 3'd5, 1'b0);
    check("t3 drop0",  64'(if0.drop_cnt), 64'd1);
    check("t3 ovf0",   64'(if0.err_fifo_overflow), 64'd1);
    check("t3 head0",  64'(if0.err_code), 64'd1);
    check("t4 drop1a", 64'(if1.drop_cnt), 64'd1);
    check("t4 ovf1",   64'(if1.err_fifo_overflow), 64'd1);
    check("t4 head1a", 64'(if1.err_code), 64'd2);
    do_rsp(2'd1, 3'd6, 1'b0);
    check("t3 drop0b", 64'(if0.drop_cnt), 64'd2);
    check("t3 head0b", 64'(if0.err_code), 64'd1);
    check("t3 addr0b", 64'(if0.err_addr), 64'h100);
    check("t4 drop1b", 64'(if1.drop_cnt), 64'd2);
    check("t4 head1b", 64'(if1.err_code), 64'd3);
    check("t4 addr1b", 64'(if1.err_addr), 64'h300);
    check("t4 id1b",   64'(if1.err_id), 64'd2);
    rsp_v = 1'b1; rsp_id = 2'd2; rsp_err = 3'd7; rsp_last = 1'b0; pop = 1'b1;
    tick();
    idle();
    check("t4 pushpop drop0", 64'(if0.drop_cnt), 64'd2);
    check("t4 pushpop head0", 64'(if0.err_code), 64'd2);
    check("t4 pushpop drop1", 64'(if1.drop_cnt), 64'd2);
    check("t4 pushpop head1", 64'(if1.err_code), 64'd4);
    rsp_v = 1'b1; rsp_id = 2'd3; rsp_err = 3'd1; rsp_last = 1'b0; clr = 1'b1;
    tick();
    idle();
    check("t3 clr drop0", 64'(if0.drop_cnt), 64'd0);
    check("t3 clr ovf0",  64'(if0.err_fifo_overflow), 64'd0);
    check("t4 clr drop1", 64'(if1.drop_cnt), 64'd0);
    check("t4 clr ovf1",  64'(if1.err_fifo_overflow), 64'd0);
    check("t4 clr head1", 64'(if1.err_code), 64'd5);
    check("t3 clr head0", 64'(if0.err_code), 64'd2);
    repeat (4) do_pop();
    check("drain irq0", 64'(if0.err_irq), 64'd0);
    check("drain irq1", 64'(if1.err_irq), 64'd0);
    do_pop();
    check("empty pop irq",  64'(if0.err_irq), 64'd0);
    check("empty pop code", 64'(if0.err_code), 64'd0);
    check("empty pop drop", 64'(if0.drop_cnt), 64'd0);
    for (int i = 0; i < 4; i++) do_rsp(2'(i), 3'd0, 1'b1);

    // reset in the middle of a burst
    do_req(2'd1, 48'h77, 1'b0);
    do_rsp(2'd1, 3'd6, 1'b0);
    check("t6 pre-rst irq", 64'(if0.err_irq), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6 rst irq0", 64'(if0.err_irq), 64'd0);
    check("t6 rst irq1", 64'(if1.err_irq), 64'd0);
    check("t6 rst code", 64'(if0.err_code), 64'd0);
    do_req(2'd1, 48'h88, 1'b1);
    do_rsp(2'd1, 3'd4, 1'b1);
    check("t6 fresh av",   64'(if0.err_addr_valid), 64'd1);
    check("t6 fresh addr", 64'(if0.err_addr), 64'h88);
    do_pop();

`ifdef BUS_ERR_UNIT_TIMEOUT_EN
    do_req(2'd0, 48'h4000, 1'b1);
    n = 0;
    while (!if0.err_irq && n < 1200) begin
      tick();
      n++;
    end
    check("tmo cycles", 64'(n), 64'd1024);
    check("tmo code",   64'(if0.err_code), 64'd7);
    check("tmo id",     64'(if0.err_id), 64'd0);
    check("tmo addr",   64'(if0.err_addr), 64'h4000);
    check("tmo av",     64'(if0.err_addr_valid), 64'd1);
    check("tmo chan",   64'(if0.err_chan), 64'd1);
    check("tmo irq1",   64'(if1.err_irq), 64'd1);
    do_pop();
    do_req(2'd0, 48'h5000, 1'b0);
    do_rsp(2'd0, 3'd1, 1'b1);
    check("tmo freed av",   64'(if0.err_addr_valid), 64'd1);
    check("tmo freed addr", 64'(if0.err_addr), 64'h5000);
    do_pop();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
